// File: rtl/envelope_follower_if.sv
// Signal bundle between a waveform source / control block and envelope_follower.
// The linear-mode control line exists only when ENV_FOLLOWER_LINEAR_EN is defined.
interface envelope_follower_if #(
  parameter int WAVE_DEPTH = 8,
  parameter int HOLD_DEPTH = 16
);
  // sample_valid is a one-cycle strobe qualifying sample; there is no back-pressure,
  // and envelope_valid pulses for exactly one cycle, two clocks after each strobe.
  logic                  sample_valid;
  logic [WAVE_DEPTH-1:0] sample;
  logic [WAVE_DEPTH-1:0] attack;
  logic [WAVE_DEPTH-1:0] release_code;
  logic [WAVE_DEPTH-1:0] threshold;
  logic [WAVE_DEPTH-1:0] hysteresis;
  logic [HOLD_DEPTH-1:0] hold_time;
`ifdef ENV_FOLLOWER_LINEAR_EN
  logic                  linear;
`endif
  logic [WAVE_DEPTH-1:0] envelope;
  logic                  envelope_valid;
  logic                  gate;
  logic [1:0]            follow_state;

`ifdef ENV_FOLLOWER_LINEAR_EN
  modport master (output sample_valid, sample, attack, release_code, threshold,
                         hysteresis, hold_time, linear,
                  input  envelope, envelope_valid, gate, follow_state);
  modport slave  (input  sample_valid, sample, attack, release_code, threshold,
                         hysteresis, hold_time, linear,
                  output envelope, envelope_valid, gate, follow_state);
`else
  modport master (output sample_valid, sample, attack, release_code, threshold,
                         hysteresis, hold_time,
                  input  envelope, envelope_valid, gate, follow_state);
  modport slave  (input  sample_valid, sample, attack, release_code, threshold,
                         hysteresis, hold_time,
                  output envelope, envelope_valid, gate, follow_state);
`endif
endinterface

// File: rtl/envelope_follower.sv
// Audio envelope follower: rectify -> attack/release smoothing -> hysteretic gate with hold.
// Optional linear (fixed-step, prescaled) smoothing mode under ENV_FOLLOWER_LINEAR_EN.
module envelope_follower #(
  parameter int WAVE_DEPTH = 8,
  parameter int HOLD_DEPTH = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  envelope_follower_if.slave bus
);
  localparam int W = WAVE_DEPTH;
  localparam logic [W-1:0] WAVE_MAX = {W{1'b1}};
  localparam logic [W-1:0] MID      = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OPEN = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  logic [W-1:0]          r_level;
  logic                  r_level_valid;
  logic [W-1:0]          r_envelope;
  logic                  r_env_valid;
  state_t                r_state;
  logic [HOLD_DEPTH-1:0] r_hold;

  logic [W:0]     w_mag2;
  logic [W-1:0]   w_level;
  logic           w_rise;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_code;
  logic [W:0]     w_rate;
  logic [2*W:0]   w_prod;
  logic [W:0]     w_step_raw;
  logic [W-1:0]   w_step;
  logic [W-1:0]   w_env_next;
  logic [W-1:0]   w_close;
  state_t         w_state_next;
  logic           w_hold_load;
  logic           w_hold_dec;
  logic           w_unused;

  // Full-wave rectify around MID, doubled so full swing maps onto 0..WAVE_MAX.
  always_comb begin
    if (bus.sample >= MID) w_mag2 = {(bus.sample - MID), 1'b0};
    else                   w_mag2 = {(MID - bus.sample), 1'b0};
    w_level = w_mag2[W] ? WAVE_MAX : w_mag2[W-1:0];
  end

  // Step = (MAX+1-code)*diff >> W never exceeds diff, so no clamping is needed.
  always_comb begin
    w_rise     = r_level > r_envelope;
    w_diff     = w_rise ? (r_level - r_envelope) : (r_envelope - r_level);
    w_code     = w_rise ? bus.attack : bus.release_code;
    w_rate     = {1'b1, {W{1'b0}}} - {1'b0, w_code};
    w_prod     = {{W{1'b0}}, w_rate} * {{(W+1){1'b0}}, w_diff};
    w_step_raw = w_prod[2*W:W];
    w_step     = (w_step_raw == '0) ? {{(W-1){1'b0}}, 1'b1} : w_step_raw[W-1:0];
  end

  assign w_unused = ^w_prod[W-1:0];

`ifdef ENV_FOLLOWER_LINEAR_EN
  logic [W-1:0] r_prescale;
  logic         r_lin_dir;
  logic [W-1:0] w_pre_cnt;
  logic         w_lin_move;

  // A direction change restarts the prescale count from zero.
  always_comb begin
    w_pre_cnt  = (w_rise != r_lin_dir) ? '0 : r_prescale;
    w_lin_move = (w_pre_cnt >= w_code);
  end
`endif

  always_comb begin
    w_env_next = r_envelope;
    if (w_diff != '0) w_env_next = w_rise ? (r_envelope + w_step) : (r_envelope - w_step);
`ifdef ENV_FOLLOWER_LINEAR_EN
    if (bus.linear && (w_diff != '0)) begin
      if (w_lin_move) w_env_next = w_rise ? (r_envelope + 1'b1) : (r_envelope - 1'b1);
      else            w_env_next = r_envelope;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level       <= '0;
      r_level_valid <= 1'b0;
      r_envelope    <= '0;
      r_env_valid   <= 1'b0;
`ifdef ENV_FOLLOWER_LINEAR_EN
      r_prescale    <= '0;
      r_lin_dir     <= 1'b0;
`endif
    end else begin
      r_level_valid <= bus.sample_valid;
      if (bus.sample_valid) r_level <= w_level;
      r_env_valid <= r_level_valid;
      if (r_level_valid) begin
        r_envelope <= w_env_next;
`ifdef ENV_FOLLOWER_LINEAR_EN
        if (bus.linear && (w_diff != '0)) begin
          r_lin_dir  <= w_rise;
          r_prescale <= w_lin_move ? '0 : (w_pre_cnt + 1'b1);
        end
`endif
      end
    end
  end

  assign bus.envelope       = r_envelope;
  assign bus.envelope_valid = r_env_valid;

  // Gate FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hold_load)     r_hold <= bus.hold_time;
      else if (w_hold_dec) r_hold <= r_hold - 1'b1;
    end
  end

  // Gate FSM: next state. A close level floored at 0 means OPEN can never close.
  always_comb begin
    w_close      = (bus.threshold > bus.hysteresis) ? (bus.threshold - bus.hysteresis) : '0;
    w_state_next = r_state;
    w_hold_load  = 1'b0;
    w_hold_dec   = 1'b0;
    case (r_state)
      ST_IDLE: if (r_envelope >= bus.threshold) w_state_next = ST_OPEN;
      ST_OPEN: begin
        if (r_envelope < w_close) begin
          w_state_next = ST_HOLD;
          w_hold_load  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_envelope >= bus.threshold) w_state_next = ST_OPEN;
        else if (r_hold == '0)           w_state_next = ST_IDLE;
        else                             w_hold_dec   = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Gate FSM: outputs decoded from the state register only.
  always_comb begin
    bus.gate         = (r_state != ST_IDLE);
    bus.follow_state = r_state;
  end
endmodule

// File: tb/tb_envelope_follower.sv
// Bench for envelope_follower: directed scenarios plus randomized bursts, checked every
// cycle against an integer reference model of the envelope and gate behaviour.
module tb_envelope_follower;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;

  envelope_follower_if #(.WAVE_DEPTH(8), .HOLD_DEPTH(16)) ef ();

  envelope_follower #(.WAVE_DEPTH(8), .HOLD_DEPTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          m_env, m_pend, m_state, m_hold;
  bit          m_vld;

  function automatic int level_of(input int s);
    int l;
    l = (s >= 128) ? 2 * (s - 128) : 2 * (128 - s);
    return (l > 255) ? 255 : l;
  endfunction

  function automatic int smooth(input int e, input int l, input int a, input int r);
    int st;
    if (l > e) begin
      st = ((256 - a) * (l - e)) / 256;
      return e + ((st == 0) ? 1 : st);
    end else if (l < e) begin
      st = ((256 - r) * (e - l)) / 256;
      return e - ((st == 0) ? 1 : st);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    int thr, close;
    cyc++;
    if (rst) begin
      m_env = 0; m_pend = 0; m_state = 0; m_hold = 0; m_vld = 0;
      exp_q.delete();
      due_q.delete();
    end else begin
      thr   = int'(ef.threshold);
      close = (thr > int'(ef.hysteresis)) ? thr - int'(ef.hysteresis) : 0;
      if (m_state == 0) begin
        if (m_env >= thr) m_state = 1;
      end else if (m_state == 1) begin
        if (m_env < close) begin m_state = 2; m_hold = int'(ef.hold_time); end
      end else begin
        if (m_env >= thr)     m_state = 1;
        else if (m_hold == 0) m_state = 0;
        else                  m_hold--;
      end
      m_vld = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        m_env = int'(exp_q.pop_front());
        void'(due_q.pop_front());
        m_vld = 1;
      end
      if (ef.sample_valid) begin
        m_pend = smooth(m_pend, level_of(int'(ef.sample)), int'(ef.attack), int'(ef.release_code));
        exp_q.push_back(32'(m_pend));
        due_q.push_back(cyc + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("env_valid", 32'(ef.envelope_valid), 32'(m_vld));
      check("envelope", 32'(ef.envelope), 32'(m_env));
      check("state", 32'(ef.follow_state), 32'(m_state));
      check("gate", 32'(ef.gate), 32'(m_state != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int s);
    @(negedge clk);
    ef.sample_valid = 1'b1;
    ef.sample       = 8'(s);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      ef.sample_valid = 1'b0;
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int a, input int r, input int t, input int h, input int ht);
    ef.attack       = 8'(a);
    ef.release_code = 8'(r);
    ef.threshold    = 8'(t);
    ef.hysteresis   = 8'(h);
    ef.hold_time    = 16'(ht);
  endtask

  task automatic wait_state(input int st);
    for (int i = 0; i < 60 && int'(ef.follow_state) != st; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_att[4];
    int holds, lows, nb;
    exp_att = '{127, 190, 222, 238};
    n_checks = 0; n_pass = 0; cyc = 0;
    rst = 1'b1;
    ef.sample_valid = 1'b1;
    ef.sample       = 8'd0;
`ifdef ENV_FOLLOWER_LINEAR_EN
    ef.linear       = 1'b0;
`endif
    set_cfg(0, 0, 100, 20, 10);

    // Reset with live inputs
    repeat (4) begin
      @(negedge clk);
      check("rst_env", 32'(ef.envelope), 0);
      check("rst_ev", 32'(ef.envelope_valid), 0);
      check("rst_gate", 32'(ef.gate), 0);
      check("rst_state", 32'(ef.follow_state), 0);
    end
    ef.sample_valid = 1'b0;
    rst = 1'b0;
    set_cfg(0, 0, 255, 0, 0);

    // Instant attack: two clocks to a one-cycle valid pulse
    send(255); quiet(1);
    check("inst_pre_ev", 32'(ef.envelope_valid), 0);
    @(negedge clk);
    check("inst_env", 32'(ef.envelope), 254);
    check("inst_ev", 32'(ef.envelope_valid), 1);
    @(negedge clk);
    check("inst_ev_drop", 32'(ef.envelope_valid), 0);

    // Exponential attack
    rst_pulse();
    ef.attack = 8'd128;
    for (int i = 0; i < 4; i++) begin
      send(255); quiet(1); @(negedge clk);
      check("exp_attack", 32'(ef.envelope), 32'(exp_att[i]));
      quiet(1);
    end

    // Slow release from 10
    rst_pulse();
    ef.attack = 8'd0;
    send(133); quiet(1); @(negedge clk);
    check("rel_start", 32'(ef.envelope), 10);
    quiet(1);
    ef.release_code = 8'd255;
    for (int i = 0; i < 10; i++) begin
      send(128); quiet(1); @(negedge clk);
      check("slow_release", 32'(ef.envelope), 32'(9 - i));
    end

    // Gate hysteresis and hold
    rst_pulse();
    set_cfg(0, 0, 100, 20, 10);
    send(255); quiet(1); @(negedge clk);
    check("gate_env", 32'(ef.envelope), 254);
    check("gate_pre", 32'(ef.gate), 0);
    @(negedge clk);
    check("gate_rise", 32'(ef.gate), 1);
    send(128); quiet(1);
    holds = 0;
    repeat (30) begin
      @(negedge clk);
      if (ef.follow_state == 2'b10) holds++;
    end
    check("hold_cycles", 32'(holds), 11);
    check("hold_end_state", 32'(ef.follow_state), 0);

    // Re-open during hold
    send(255); quiet(1);
    wait_state(1);
    send(128); quiet(1);
    wait_state(2);
    check("reopen_in_hold", 32'(ef.follow_state), 2);
    quiet(3);
    send(255); quiet(1);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ef.gate) lows++;
    end
    check("reopen_gate_low", 32'(lows), 0);
    check("reopen_state", 32'(ef.follow_state), 1);

    // Reset mid-hold
    send(128); quiet(1);
    wait_state(2);
    rst_pulse();
    check("rhold_env", 32'(ef.envelope), 0);
    check("rhold_state", 32'(ef.follow_state), 0);
    check("rhold_gate", 32'(ef.gate), 0);
    send(255); quiet(1); @(negedge clk);
    check("rhold_recover", 32'(ef.envelope), 254);

    // Reset mid-attack
    rst_pulse();
    ef.attack = 8'd200;
    send(255); send(255); send(255);
    rst = 1'b1;
    ef.sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("ratk_env", 32'(ef.envelope), 0);
    check("ratk_ev", 32'(ef.envelope_valid), 0);
    ef.attack = 8'd0;
    send(255); quiet(1); @(negedge clk);
    check("ratk_recover", 32'(ef.envelope), 254);
    quiet(2);

    // Randomized bursts, occasional resets and edge-case gate settings
    for (int it = 0; it < 250; it++) begin
      set_cfg($urandom_range(0, 255), $urandom_range(0, 255),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255),
              ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40),
              $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ef.attack = 8'($urandom_range(0, 1) * 255);
      nb = $urandom_range(1, 12);
      for (int k = 0; k < nb; k++) begin
        send($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) quiet($urandom_range(1, 2));
      end
      quiet(2);
      if ($urandom_range(0, 19) == 0) rst_pulse();
      quiet($urandom_range(0, 20));
    end
    quiet(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Inverse of the ADSR generator. Takes an audio-rate waveform and produces a smoothed amplitude envelope plus a derived Gate.
- Sits after an oscillator, filter or external input. Its Gate can drive an ADSR or VCA as an audio-triggered gate.
- Attack and release smoothing use the same rate-code style as the ADSR: larger code means slower.

Parameters:
- WAVE_DEPTH, 8, sample/envelope/rate width; WAVE_MAX = 2^WAVE_DEPTH-1, MID = 2^(WAVE_DEPTH-1).
- HOLD_DEPTH, 16, width of the gate hold counter.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- SampleValid  input  1  one-cycle strobe, Sample is valid.
- Sample  input  WAVE_DEPTH  unsigned offset-binary waveform, MID = zero.
- Attack  input  WAVE_DEPTH  rise rate code, 0 = instant, WAVE_MAX = slowest.
- Release  input  WAVE_DEPTH  fall rate code, 0 = instant, WAVE_MAX = slowest.
- Threshold  input  WAVE_DEPTH  gate-open level.
- Hysteresis  input  WAVE_DEPTH  gate closes below Threshold-Hysteresis.
- HoldTime  input  HOLD_DEPTH  clocks Gate stays high after dropping below close level.
- Envelope  output  WAVE_DEPTH  registered envelope.
- EnvelopeValid  output  1  one-cycle pulse when Envelope is updated.
- Gate  output  1  high in OPEN or HOLD.
- FollowState  output  2  00 IDLE, 01 OPEN, 10 HOLD (11 unused).

Behaviour:
- Reset (sync, high): Envelope=0, EnvelopeValid=0, FollowState=IDLE, Gate=0, hold counter=0, level register=0. Reset has priority over all events, including mid-attack and mid-hold. Inputs are ignored while Reset=1.
- Stage 1, on SampleValid: level = (Sample>=MID) ? 2*(Sample-MID) : 2*(MID-Sample), saturated to WAVE_MAX. Level is registered.
  - Examples: Sample 128 -> 0, 255 -> 254, 0 -> 255 (saturated).
- Stage 2, the clock after stage 1: Envelope update, EnvelopeValid=1 for that cycle. Latency is SampleValid to Envelope/EnvelopeValid = 2 clocks. Back-to-back SampleValid every clock is supported, fully pipelined.
- Update arithmetic, with diff width WAVE_DEPTH and product width 2*WAVE_DEPTH+1:
  - level>Envelope: step = ((WAVE_MAX+1-Attack)*(level-Envelope))>>WAVE_DEPTH, forced to 1 if 0. Envelope += step.
  - level<Envelope: step = ((WAVE_MAX+1-Release)*(Envelope-level))>>WAVE_DEPTH, forced to 1 if 0. Envelope -= step.
  - level==Envelope: no change, EnvelopeValid still pulses.
  - Step never exceeds diff, so no overshoot, wrap or saturation is needed.
- Gate FSM, evaluated every clock on the registered Envelope. FollowState updates one clock after Envelope.
  - IDLE: Envelope>=Threshold -> OPEN.
  - OPEN: Envelope<closeLevel -> HOLD and load hold counter=HoldTime. closeLevel = Threshold-Hysteresis, floored at 0. If Threshold<=Hysteresis, OPEN never closes.
  - HOLD: if Envelope>=Threshold -> OPEN (re-open has priority). Else if counter==0 -> IDLE. Else counter decrements.
  - Gate is high for HoldTime+1 cycles in HOLD. HoldTime=0 gives a single HOLD cycle.
  - Threshold=0 means the gate is always open after the first clock out of reset.
- Gate = (FollowState!=IDLE), derived from the state register, glitch-free.
- Rate or threshold input changes take effect on the next update or comparison. Nothing is latched.

Optional Feature:
- Macro ENV_FOLLOWER_LINEAR_EN.
- Defined:
  - Adds a Linear input (1 bit) and a WAVE_DEPTH-bit prescale counter.
  - When Linear=1, each update moves Envelope by exactly 1 toward level.
  - A move happens only every (Attack+1), or (Release+1), valid samples. The counter counts valid samples and resets after each move and on direction change.
  - Linear=0 gives the exponential behaviour above.
- Undefined: no Linear port, no prescale counter, exponential only.

Test Plan:
- Reset: hold Reset=1 with SampleValid/Sample=0 active -> Envelope=0, EnvelopeValid=0, Gate=0, FollowState=00 every cycle.
- Instant attack: Attack=0, one SampleValid with Sample=255 -> two clocks later Envelope=254, EnvelopeValid=1 for exactly one cycle.
- Exponential attack: Attack=128, Envelope=0, Sample=255 every 4 clocks -> Envelope 127, 190, 222, 238. Slow release: Release=255, Envelope=10, Sample=128 -> decrements by 1 per sample to 0.
- Gate hysteresis and hold: Threshold=100, Hysteresis=20, HoldTime=10, Attack=Release=0.
  - Sample=255 -> Gate rises one clock after Envelope=254.
  - Sample 128 -> Envelope 0, FollowState=HOLD, Gate stays high 11 cycles, then IDLE.
- Re-open in hold: same setup, Sample=255 on HOLD cycle 5 -> FollowState returns to OPEN, Gate never drops.
- Reset mid-HOLD and mid-attack: assert Reset for one clock -> all outputs return to reset values next clock. The next valid Sample=255 with Attack=0 yields Envelope=254.
